// File: rtl/decode_stage_if.sv
// Register-file read port between the decode stage (master) and the register file (slave).
interface decode_stage_if #(
  parameter int DW = 32
);
  logic [3:0]    srcA;
  logic [3:0]    srcB;
  logic [DW-1:0] rf_valA;
  logic [DW-1:0] rf_valB;

  modport master (output srcA, output srcB, input rf_valA, input rf_valB);
  modport slave  (input srcA, input srcB, output rf_valA, output rf_valB);
endinterface

// File: rtl/decode_stage.sv
// Y86 decode stage: D pipeline register, register-field decode, E/M/W forwarding,
// load-use hazard detection and the E pipeline register feeding execute.
module decode_stage #(
  parameter int         DW    = 32,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RESP  = 4'h4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    f_icode,
  input  logic [3:0]    f_ifun,
  input  logic [3:0]    f_rA,
  input  logic [3:0]    f_rB,
  input  logic [DW-1:0] f_valC,
  input  logic [DW-1:0] f_valP,
  input  logic          ext_bubble_d,
  input  logic          ext_bubble_e,
  decode_stage_if.master rf,
  input  logic [3:0]    e_dstE,
  input  logic [DW-1:0] e_valE,
  input  logic [3:0]    M_dstE,
  input  logic [DW-1:0] M_valE,
  input  logic [3:0]    M_dstM,
  input  logic [DW-1:0] m_valM,
  input  logic [3:0]    W_dstE,
  input  logic [DW-1:0] W_valE,
  input  logic [3:0]    W_dstM,
  input  logic [DW-1:0] W_valM,
  input  logic [3:0]    E_dstM_in,
  input  logic [3:0]    E_icode_in,
  output logic          stall_f,
  output logic [3:0]    E_icode,
  output logic [3:0]    E_ifun,
  output logic [DW-1:0] E_valC,
  output logic [DW-1:0] E_valA,
  output logic [DW-1:0] E_valB,
  output logic [3:0]    E_dstE,
  output logic [3:0]    E_dstM,
  output logic [3:0]    E_srcA,
  output logic [3:0]    E_srcB
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  logic [3:0]    d_icode, d_ifun, d_rA, d_rB;
  logic [DW-1:0] d_valC, d_valP;
  logic [3:0]    d_srcA, d_srcB, d_dstE, d_dstM;
  logic [DW-1:0] fwd_valA, fwd_valB;
  logic          load_use;

  // A tag of RNONE never matches, even against a source of RNONE.
  function automatic logic hit(input logic [3:0] tag, input logic [3:0] src);
    return (tag != RNONE) && (tag == src);
  endfunction

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (d_icode)
      I_RRMOVL, I_RMMOVL, I_OPL, I_PUSHL: d_srcA = d_rA;
      I_POPL, I_RET:                      d_srcA = RESP;
      default: ;
    endcase
    case (d_icode)
      I_OPL, I_RMMOVL, I_MRMOVL:          d_srcB = d_rB;
      I_PUSHL, I_POPL, I_CALL, I_RET:     d_srcB = RESP;
      default: ;
    endcase
    case (d_icode)
      I_RRMOVL, I_IRMOVL, I_OPL:          d_dstE = d_rB;
      I_PUSHL, I_POPL, I_CALL, I_RET:     d_dstE = RESP;
      default: ;
    endcase
    case (d_icode)
      I_MRMOVL, I_POPL:                   d_dstM = d_rA;
      default: ;
    endcase
  end

  assign rf.srcA = d_srcA;
  assign rf.srcB = d_srcB;

  always_comb begin
    fwd_valA = rf.rf_valA;
    if (d_icode == I_CALL || d_icode == I_JXX) fwd_valA = d_valP;
    else if (hit(e_dstE, d_srcA))              fwd_valA = e_valE;
    else if (hit(M_dstM, d_srcA))              fwd_valA = m_valM;
    else if (hit(M_dstE, d_srcA))              fwd_valA = M_valE;
    else if (hit(W_dstM, d_srcA))              fwd_valA = W_valM;
    else if (hit(W_dstE, d_srcA))              fwd_valA = W_valE;
  end

  always_comb begin
    fwd_valB = rf.rf_valB;
    if      (hit(e_dstE, d_srcB)) fwd_valB = e_valE;
    else if (hit(M_dstM, d_srcB)) fwd_valB = m_valM;
    else if (hit(M_dstE, d_srcB)) fwd_valB = M_valE;
    else if (hit(W_dstM, d_srcB)) fwd_valB = W_valM;
    else if (hit(W_dstE, d_srcB)) fwd_valB = W_valE;
  end

  assign load_use = ((E_icode_in == I_MRMOVL) || (E_icode_in == I_POPL)) &&
                    (E_dstM_in != RNONE) &&
                    ((E_dstM_in == d_srcA) || (E_dstM_in == d_srcB));
  assign stall_f  = load_use;

  // A control-unit bubble wins over the load-use hold so a squashed instruction never lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || ext_bubble_d) begin
      d_icode <= I_NOP;
      d_ifun  <= 4'h0;
      d_rA    <= RNONE;
      d_rB    <= RNONE;
      d_valC  <= '0;
      d_valP  <= '0;
    end else if (!load_use) begin
      d_icode <= f_icode;
      d_ifun  <= f_ifun;
      d_rA    <= f_rA;
      d_rB    <= f_rB;
      d_valC  <= f_valC;
      d_valP  <= f_valP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || load_use || ext_bubble_e) begin
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else begin
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= fwd_valA;
      E_valB  <= fwd_valB;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: decode, forwarding priority, load-use and bubbles.
module tb_decode_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    f_icode, f_ifun, f_rA, f_rB;
  logic [DW-1:0] f_valC, f_valP;
  logic          ext_bubble_d, ext_bubble_e;
  logic [3:0]    e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, E_dstM_in, E_icode_in;
  logic [DW-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic          stall_f;
  logic [3:0]    E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [DW-1:0] E_valC, E_valA, E_valB;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage_if #(.DW(DW)) rf_if ();

  decode_stage #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .ext_bubble_d(ext_bubble_d), .ext_bubble_e(ext_bubble_e),
    .rf(rf_if),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .E_dstM_in(E_dstM_in), .E_icode_in(E_icode_in),
    .stall_f(stall_f),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_f(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [31:0] vc, input logic [31:0] vp);
    f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
  endtask

  task automatic clear_fwd();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    E_dstM_in = 4'hF; E_icode_in = 4'h1;
  endtask

  initial begin
    rst = 1'b1;
    ext_bubble_d = 1'b0; ext_bubble_e = 1'b0;
    load_f(4'h1, 4'hF, 4'hF, 0, 0);
    clear_fwd();
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    rf_if.rf_valA = 32'h5; rf_if.rf_valB = 32'h7;
    #3;
    check("rst_srcA", rf_if.srcA, 4'hF);
    check("rst_srcB", rf_if.srcB, 4'hF);
    check("rst_stall", stall_f, 0);
    check("rst_E_icode", E_icode, 4'h1);
    check("rst_E_dstE", E_dstE, 4'hF);
    tick(); tick();
    rst = 1'b0;

    // Plain OPL with register-file operands
    load_f(4'h6, 4'h1, 4'h2, 0, 0);
    tick();
    check("opl_srcA", rf_if.srcA, 4'h1);
    check("opl_srcB", rf_if.srcB, 4'h2);
    tick();
    check("opl_E_icode", E_icode, 4'h6);
    check("opl_E_valA", E_valA, 32'h5);
    check("opl_E_valB", E_valB, 32'h7);
    check("opl_E_dstE", E_dstE, 4'h2);
    check("opl_E_dstM", E_dstM, 4'hF);

    // Asynchronous reset mid-cycle with OPL sitting in D and E
    #2 rst = 1'b1;
    #1;
    check("arst_E_icode", E_icode, 4'h1);
    check("arst_E_srcA", E_srcA, 4'hF);
    check("arst_E_srcB", E_srcB, 4'hF);
    check("arst_E_dstE", E_dstE, 4'hF);
    check("arst_E_dstM", E_dstM, 4'hF);
    check("arst_E_valA", E_valA, 0);
    check("arst_srcA", rf_if.srcA, 4'hF);
    rst = 1'b0;

    // Forwarding priority on srcA=3, srcB=2
    rf_if.rf_valA = 32'h11; rf_if.rf_valB = 32'h22;
    load_f(4'h6, 4'h3, 4'h2, 0, 0);
    tick();
    e_dstE = 4'h3; e_valE = 32'hAA; W_dstE = 4'h3; W_valE = 32'hBB;
    tick();
    check("fwd_e_over_W", E_valA, 32'hAA);
    e_dstE = 4'hF;
    tick();
    check("fwd_W_valE", E_valA, 32'hBB);
    M_dstM = 4'h3; m_valM = 32'hCC; M_dstE = 4'h3; M_valE = 32'hDD;
    tick();
    check("fwd_MdstM_over_MdstE", E_valA, 32'hCC);
    M_dstM = 4'hF;
    tick();
    check("fwd_M_valE", E_valA, 32'hDD);
    clear_fwd();
    W_dstM = 4'h2; W_valM = 32'hEE;
    tick();
    check("fwd_B_W_valM", E_valB, 32'hEE);
    check("fwd_A_rf", E_valA, 32'h11);
    clear_fwd();

    // Load-use: MRMOVL in E writes r1, OPL rA=1 in D
    load_f(4'h6, 4'h1, 4'h2, 0, 0);
    tick();
    load_f(4'h1, 4'hF, 4'hF, 0, 0);
    E_icode_in = 4'h2; E_dstM_in = 4'h1;
    #1 check("nohaz_rrmovl_stall", stall_f, 0);
    E_icode_in = 4'h5;
    #1 check("lu_stall", stall_f, 1);
    tick();
    check("lu_E_bubble", E_icode, 4'h1);
    check("lu_D_held", rf_if.srcA, 4'h1);
    E_icode_in = 4'h1; E_dstM_in = 4'hF; M_dstM = 4'h1; m_valM = 32'h42;
    #1 check("lu_release", stall_f, 0);
    tick();
    check("lu_E_icode", E_icode, 4'h6);
    check("lu_E_valA", E_valA, 32'h42);
    clear_fwd();

    // CALL / PUSHL / POPL pipelined through D and E
    rf_if.rf_valA = 32'h55;
    load_f(4'h8, 4'hF, 4'hF, 32'h200, 32'h100);
    tick();
    load_f(4'hA, 4'h6, 4'hF, 0, 0);
    tick();
    check("call_E_valA", E_valA, 32'h100);
    check("call_E_srcA", E_srcA, 4'hF);
    check("call_E_srcB", E_srcB, 4'h4);
    check("call_E_dstE", E_dstE, 4'h4);
    check("call_E_valC", E_valC, 32'h200);
    load_f(4'hB, 4'h3, 4'hF, 0, 0);
    tick();
    check("push_E_srcA", E_srcA, 4'h6);
    check("push_E_srcB", E_srcB, 4'h4);
    check("push_E_dstE", E_dstE, 4'h4);
    check("push_E_valA", E_valA, 32'h55);
    load_f(4'h0, 4'h2, 4'h3, 0, 0);
    tick();
    check("pop_E_srcA", E_srcA, 4'h4);
    check("pop_E_dstM", E_dstM, 4'h3);
    load_f(4'h1, 4'hF, 4'hF, 0, 0);
    tick();
    check("halt_E_icode", E_icode, 4'h0);
    check("halt_E_dstE", E_dstE, 4'hF);

    // ext_bubble_d beats load-use hold
    load_f(4'h6, 4'h1, 4'h2, 0, 0);
    tick();
    load_f(4'h3, 4'hF, 4'h3, 32'h77, 0);
    E_icode_in = 4'h5; E_dstM_in = 4'h1; ext_bubble_d = 1'b1;
    #1 check("bd_stall", stall_f, 1);
    tick();
    check("bd_D_bubble", rf_if.srcA, 4'hF);
    check("bd_E_bubble", E_icode, 4'h1);
    ext_bubble_d = 1'b0; clear_fwd();
    tick();
    load_f(4'h2, 4'h2, 4'h5, 0, 0);
    ext_bubble_e = 1'b1;
    tick();
    check("be_E_bubble", E_icode, 4'h1);
    check("be_D_loaded", rf_if.srcA, 4'h2);
    ext_bubble_e = 1'b0;
    tick();
    check("be_E_icode", E_icode, 4'h2);
    check("be_E_dstE", E_dstE, 4'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
